shift_register_rx: RTL
======================

// Module: shift_register_rx
// PURPOSE
//   Serial-to-parallel receiver, the far end of the shift_register serial link.
//   Samples an external serial clock/data pair (MSB first, data stable at clk rise)
//   and assembles WIDTH-bit words.
//   Presents each word with a one-cycle valid strobe.
//   Inputs are asynchronous to i_clk and are synchronised internally.
//   A stalled partial frame is discarded by an idle timeout.
// PARAMETERS
//   WIDTH           8    bits per frame (>=2)
//   SYNC_STAGES     2    synchroniser flops on serial clk/data (>=2)
//   TIMEOUT_CYCLES  64   i_clk cycles without serial clk rise that abort a partial frame (>=4)
// PORTS
//   i_clk            in   1      system clock; all state on posedge
//   i_reset_n        in   1      asynchronous active-low reset
//   i_enable         in   1      receive enable; low = ignore link, stay IDLE
//   i_serial_clk     in   1      serial clock from transmitter (async to i_clk)
//   i_serial_data    in   1      serial data, MSB first (async to i_clk)
//   o_parallel_data  out  WIDTH  last complete word; held until next word completes
//   o_data_valid     out  1      1-cycle strobe: o_parallel_data updated this cycle
//   o_frame_error    out  1      1-cycle strobe: partial frame discarded on timeout
//   o_busy           out  1      high while a frame is partially received
// BEHAVIOUR
//   Reset (async assert, sync release):
//     all synchroniser flops 0, state IDLE, bit count 0, timeout count 0, shift reg 0.
//     Outputs: o_parallel_data 0, o_data_valid 0, o_frame_error 0, o_busy 0.
//   Synchronisation:
//     clk and data each pass through SYNC_STAGES flops, then one extra clk flop (clk_d).
//     rise = clk_sync & ~clk_d.
//     Data is sampled from the data synchroniser output on the same cycle (equal depth).
//   Link timing: serial clk high and low phases are each >= 3 i_clk cycles.
//     Faster links are out of spec; no detection is required.
//   State machine (registered; state/counts update on the i_clk edge where rise is seen):
//     IDLE:
//       rise & i_enable -> shift in bit, bit count = 1, go RECEIVE.
//     RECEIVE, rise, bit count < WIDTH-1:
//       shift {sr[WIDTH-2:0], data}, count++, timeout count cleared.
//     RECEIVE, rise, bit count == WIDTH-1:
//       o_parallel_data <= {sr[WIDTH-2:0], data}, o_data_valid = 1, count 0, go IDLE.
//     RECEIVE, no rise:
//       timeout count++.
//       When it reaches TIMEOUT_CYCLES-1: o_frame_error = 1, count 0, shift reg 0, go IDLE.
//       o_parallel_data is unchanged.
//     i_enable low in RECEIVE: abort to IDLE next cycle, no error strobe.
//   Latency: last-bit clk rise at pin -> o_data_valid high SYNC_STAGES+1 i_clk edges later.
//   o_busy = (state == RECEIVE).
//   Strobes are single-cycle; o_data_valid and o_frame_error are never high together.
//   Back-to-back frames need no gap: a rise in the cycle after completion starts a new frame.
//   Falling edges of serial clk are ignored.
//     Transmitter idle level (clk 0, data 0) produces no activity.
//   Reset asserted mid-frame: partial frame lost, outputs to reset values immediately.
//   Timeout counter width = $clog2(TIMEOUT_CYCLES); it saturates, no wrap.
// TESTING
//   1 Frame 8'hA5, half-period 4 cycles
//     -> single o_data_valid, data 8'hA5, 3 edges after 8th rise; o_busy high from bit 1 to done.
//   2 Back-to-back 8'h3C then 8'hFF, no idle gap
//     -> two valid strobes, data 8'h3C then 8'hFF, o_frame_error never set.
//   3 Five bits of 8'h81 then 64+ idle cycles
//     -> o_frame_error 1 cycle, o_parallel_data holds previous value; next 8'h81 received clean.
//   4 Reset pulse after 3 bits of 8'h5A
//     -> outputs 0 during reset; following full 8'h5A frame received correctly.
//   5 Loopback from shift_register (WIDTH=8, clk_stb every 4 cycles), words 8'h00, 8'hC3, 8'hFF
//     -> all three received in order.
//   6 WIDTH=16, frame 16'hBEEF; i_enable dropped mid-frame
//     -> 16'hBEEF received; aborted frame yields no valid and no error.

Source files
------------

// File: rtl/shift_register_rx_if.sv
// Link bundle between a serial transmitter and shift_register_rx: the serial
// clock/data pair and enable in, the assembled word and its strobes out.
interface shift_register_rx_if #(
    parameter int WIDTH = 8
);
    logic             i_enable;
    logic             i_serial_clk;
    logic             i_serial_data;
    logic [WIDTH-1:0] o_parallel_data;
    logic             o_data_valid;
    logic             o_frame_error;
    logic             o_busy;

    modport master (
        output i_enable, i_serial_clk, i_serial_data,
        input  o_parallel_data, o_data_valid, o_frame_error, o_busy
    );

    modport slave (
        input  i_enable, i_serial_clk, i_serial_data,
        output o_parallel_data, o_data_valid, o_frame_error, o_busy
    );
endinterface

// File: rtl/shift_register_rx.sv
// Serial-to-parallel receiver: synchronises an external MSB-first clock/data
// pair into i_clk, assembles WIDTH-bit words and drops stalled frames on timeout.
module shift_register_rx #(
    parameter int WIDTH          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    shift_register_rx_if.slave link
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        IDLE,
        RECEIVE
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_d_q;
    logic                   clk_sync;
    logic                   data_sync;
    logic                   rise;

    state_t           state_q;
    state_t           state_next;
    logic [WIDTH-2:0] sr_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic [WIDTH-1:0] word_q;
    logic             valid_q;
    logic             error_q;
    logic [WIDTH-1:0] assembled;

    logic start;
    logic shift;
    logic complete;
    logic tick_to;
    logic timeout;
    logic abort;

    // Both chains have equal depth so data lines up with the detected clock rise.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            clk_sync_q  <= '0;
            data_sync_q <= '0;
            clk_d_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge value regardless of statement order.
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], link.i_serial_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], link.i_serial_data};
            clk_d_q     <= clk_sync;
        end
    end

    assign clk_sync  = clk_sync_q[SYNC_STAGES-1];
    assign data_sync = data_sync_q[SYNC_STAGES-1];
    assign rise      = clk_sync & ~clk_d_q;
    assign assembled = {sr_q, data_sync};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves the signal
        // unassigned and infers a latch.
        state_next = state_q;
        case (state_q)
            IDLE:    if (start) state_next = RECEIVE;
            RECEIVE: if (abort || complete || timeout) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decode what this cycle does to the frame; the datapath below just obeys.
    always_comb begin
        start    = 1'b0;
        shift    = 1'b0;
        complete = 1'b0;
        tick_to  = 1'b0;
        timeout  = 1'b0;
        abort    = 1'b0;
        case (state_q)
            IDLE: start = rise & link.i_enable;
            RECEIVE: begin
                if (!link.i_enable) begin
                    abort = 1'b1;
                end else if (rise) begin
                    if (bit_cnt_q == LAST_BIT) complete = 1'b1;
                    else                       shift    = 1'b1;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout = 1'b1;
                end else begin
                    tick_to = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Stale bits in sr_q shift out before a frame completes, so a start needs no clear.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            valid_q <= complete;
            error_q <= timeout;
            if (start || shift) begin
                sr_q      <= assembled[WIDTH-2:0];
                bit_cnt_q <= start ? CNT_W'(1) : bit_cnt_q + CNT_W'(1);
                to_cnt_q  <= '0;
            end else if (tick_to) begin
                to_cnt_q <= (to_cnt_q == TO_LAST) ? to_cnt_q : to_cnt_q + TO_W'(1);
            end else if (complete || timeout || abort) begin
                bit_cnt_q <= '0;
                to_cnt_q  <= '0;
            end
            if (complete) word_q <= assembled;
            if (timeout)  sr_q   <= '0;
        end
    end

    assign link.o_parallel_data = word_q;
    assign link.o_data_valid    = valid_q;
    assign link.o_frame_error   = error_q;
    assign link.o_busy          = (state_q == RECEIVE);
endmodule
